// File: rtl/gnrc_onehot2bin_pipe.sv
// gnrc_onehot2bin_pipe: streaming one-hot to binary encoder with valid/ready
// handshake and STAGES elastic register stages (0 = combinational pass-through).
// MODE selects OR-merge (0), lowest set bit (1) or highest set bit (2).
// All-zero and multi-hot inputs are flagged per beat on zero_o / multi_o.
// Optional macro GNRC_ONEHOT2BIN_ERRCNT_EN adds a saturating error counter
// (err_clr_i / err_cnt_o) that counts flagged output beats.
module gnrc_onehot2bin_pipe #(
  parameter  int N      = 8,
  parameter  int STAGES = 2,
  parameter  int MODE   = 0,
  parameter  int CNT_W  = 16,
  localparam int M      = $clog2(N) + ((N == 1) ? 1 : 0)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] onehot_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [M-1:0] bin_o,
  output logic         zero_o,
  output logic         multi_o
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
  ,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] err_cnt_o
`endif
);

  // Reject illegal configurations while elaborating.
  if (N < 1 || STAGES < 0 || STAGES > 4 || MODE < 0 || MODE > 2 || CNT_W < 1) begin : g_bad_param
    $fatal(1, "gnrc_onehot2bin_pipe: illegal parameters N=%0d STAGES=%0d MODE=%0d CNT_W=%0d",
           N, STAGES, MODE, CNT_W);
  end

  logic [M-1:0] enc_or;
  logic [M-1:0] enc_lo;
  logic [M-1:0] enc_hi;
  logic [M-1:0] enc_bin;
  logic         enc_seen;
  logic         enc_zero;
  logic         enc_multi;

  // Full encode in front of the first stage; later stages only carry the result.
  always_comb begin
    enc_or    = '0;
    enc_lo    = '0;
    enc_hi    = '0;
    enc_seen  = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) begin
        enc_or    = enc_or | M'(i);
        if (!enc_seen) enc_lo = M'(i);
        enc_hi    = M'(i);
        enc_multi = enc_multi | enc_seen;
        enc_seen  = 1'b1;
      end
    end
    enc_zero = !enc_seen;
    if (MODE == 1)      enc_bin = enc_lo;
    else if (MODE == 2) enc_bin = enc_hi;
    else                enc_bin = enc_or;
  end

  if (STAGES == 0) begin : g_comb
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign bin_o   = enc_bin;
    assign zero_o  = enc_zero;
    assign multi_o = enc_multi;
  end else begin : g_pipe
    logic [STAGES:0]   stg_rdy;
    logic [STAGES-1:0] stg_v;
    logic [STAGES-1:0] stg_zero;
    logic [STAGES-1:0] stg_multi;
    logic [M-1:0]      stg_bin [STAGES];

    // Ready chain: a stage accepts when it is empty or its successor accepts,
    // so bubbles collapse even while the output is stalled.
    always_comb begin
      stg_rdy         = '0;
      stg_rdy[STAGES] = ready_i;
      for (int k = STAGES - 1; k >= 0; k--) begin
        stg_rdy[k] = !stg_v[k] || stg_rdy[k+1];
      end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic         in_v, in_zero, in_multi;
      logic [M-1:0] in_bin;
      logic         v_q, v_d, zero_q, zero_d, multi_q, multi_d;
      logic [M-1:0] bin_q, bin_d;

      if (gi == 0) begin : g_head
        assign in_v     = valid_i;
        assign in_bin   = enc_bin;
        assign in_zero  = enc_zero;
        assign in_multi = enc_multi;
      end else begin : g_body
        assign in_v     = stg_v[gi-1];
        assign in_bin   = stg_bin[gi-1];
        assign in_zero  = stg_zero[gi-1];
        assign in_multi = stg_multi[gi-1];
      end

      // Next state: advance when ready, otherwise hold (keeps payload stable in a stall).
      always_comb begin
        v_d     = v_q;
        bin_d   = bin_q;
        zero_d  = zero_q;
        multi_d = multi_q;
        if (stg_rdy[gi]) begin
          v_d = in_v;
          if (in_v) begin
            bin_d   = in_bin;
            zero_d  = in_zero;
            multi_d = in_multi;
          end
        end
      end

      // Stage register; reset discards any beat held here.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_q     <= 1'b0;
          bin_q   <= '0;
          zero_q  <= 1'b0;
          multi_q <= 1'b0;
        end else begin
          v_q     <= v_d;
          bin_q   <= bin_d;
          zero_q  <= zero_d;
          multi_q <= multi_d;
        end
      end

      assign stg_v[gi]     = v_q;
      assign stg_bin[gi]   = bin_q;
      assign stg_zero[gi]  = zero_q;
      assign stg_multi[gi] = multi_q;
    end

    // Input side is closed while reset is held even though all stages read empty.
    assign ready_o = stg_rdy[0] && !rst_i;
    assign valid_o = stg_v[STAGES-1];
    assign bin_o   = stg_bin[STAGES-1];
    assign zero_o  = stg_zero[STAGES-1];
    assign multi_o = stg_multi[STAGES-1];
  end

`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count flagged output handshakes, saturating; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (valid_o && ready_i && (zero_o || multi_o) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_gnrc_onehot2bin_pipe.sv
// Bench for gnrc_onehot2bin_pipe: three N=8 STAGES=2 instances (MODE 0/1/2) on a
// shared stream checked by a queue scoreboard, plus an N=13 STAGES=0 MODE2 instance.
module tb_gnrc_onehot2bin_pipe;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i, ready_i, err_clr_i;
  logic [7:0] onehot_i;
  logic       valid_o, ready_o, zero_o, multi_o;
  logic [2:0] bin_o;
  logic       d1_valid, d1_ready, d1_zero, d1_multi;
  logic       d2_valid, d2_ready, d2_zero, d2_multi;
  logic [2:0] d1_bin, d2_bin;
  logic        c_valid_i, c_ready_i, c_valid_o, c_ready_o, c_zero, c_multi;
  logic [12:0] c_onehot;
  logic [3:0]  c_bin;
  logic [1:0]  err_cnt_o, d1_err, d2_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  gnrc_onehot2bin_pipe #(.N(8), .STAGES(2), .MODE(0), .CNT_W(2)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .onehot_i(onehot_i),
    .valid_o(valid_o), .ready_i(ready_i), .bin_o(bin_o), .zero_o(zero_o), .multi_o(multi_o)
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
    , .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o)
`endif
  );

  gnrc_onehot2bin_pipe #(.N(8), .STAGES(2), .MODE(1), .CNT_W(2)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(d1_ready), .onehot_i(onehot_i),
    .valid_o(d1_valid), .ready_i(ready_i), .bin_o(d1_bin), .zero_o(d1_zero), .multi_o(d1_multi)
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
    , .err_clr_i(err_clr_i), .err_cnt_o(d1_err)
`endif
  );

  gnrc_onehot2bin_pipe #(.N(8), .STAGES(2), .MODE(2), .CNT_W(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(d2_ready), .onehot_i(onehot_i),
    .valid_o(d2_valid), .ready_i(ready_i), .bin_o(d2_bin), .zero_o(d2_zero), .multi_o(d2_multi)
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
    , .err_clr_i(err_clr_i), .err_cnt_o(d2_err)
`endif
  );

  gnrc_onehot2bin_pipe #(.N(13), .STAGES(0), .MODE(2), .CNT_W(2)) u_comb (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(c_valid_i), .ready_o(c_ready_o), .onehot_i(c_onehot),
    .valid_o(c_valid_o), .ready_i(c_ready_i), .bin_o(c_bin), .zero_o(c_zero), .multi_o(c_multi)
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
    , .err_clr_i(err_clr_i), .err_cnt_o()
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: list the set bit positions, then apply the mode rule to that list.
  function automatic void ref_encode(input logic [31:0] x, input int n, input int mode,
                                     output int b, output bit z, output bit m);
    int idx[$];
    b = 0;
    for (int i = 0; i < n; i++) if (x[i]) idx.push_back(i);
    z = (idx.size() == 0);
    m = (idx.size() > 1);
    if (!z) begin
      if (mode == 1)      b = idx[0];
      else if (mode == 2) b = idx[idx.size()-1];
      else foreach (idx[k]) b = b | idx[k];
    end
  endfunction

  function automatic logic [31:0] rand_vec(input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    case ($urandom_range(0, 3))
      0:       rand_vec = 32'd0;
      3:       rand_vec = $urandom & mask;
      default: rand_vec = 32'd1 << $urandom_range(0, n - 1);
    endcase
  endfunction

  typedef struct { logic [7:0] oh; int acc; } beat_t;
  beat_t sbq[$];
  int    cyc = 0;
  int    last_low = -1;
  int    beat_no = 0;
  bit    held = 0;
  logic [2:0] held_bin;
  logic       held_zero, held_multi;
  int    err_m = 0;

  // Scoreboard monitor, sampled on the falling edge (inputs change just after rising edges).
  always @(negedge clk_i) begin
    bit hs_err;
    hs_err = 0;
    cyc++;
    if (rst_i) begin
      check_eq("rst_valid_o", valid_o, 0);
      check_eq("rst_ready_o", ready_o, 0);
      check_eq("rst_bin_o", bin_o, 0);
      check_eq("rst_flags", {zero_o, multi_o}, 0);
      sbq.delete();
      held  = 0;
      err_m = 0;
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
      check_eq("rst_err_cnt", err_cnt_o, 0);
`endif
    end else begin
      if (held) begin
        check_eq("stall_valid_o", valid_o, 1);
        check_eq("stall_bin_o", bin_o, held_bin);
        check_eq("stall_flags", {zero_o, multi_o}, {held_zero, held_multi});
      end
      if (valid_o && ready_i) begin
        check_eq("beat_expected", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          beat_t e;
          int b0, b1, b2;
          bit z, m;
          e = sbq.pop_front();
          ref_encode(e.oh, 8, 0, b0, z, m);
          ref_encode(e.oh, 8, 1, b1, z, m);
          ref_encode(e.oh, 8, 2, b2, z, m);
          $display("beat %0d onehot=%02h bin0=%0d bin1=%0d bin2=%0d zero=%0d multi=%0d",
                   beat_no, e.oh, bin_o, d1_bin, d2_bin, zero_o, multi_o);
          beat_no++;
          check_eq("bin_mode0", bin_o, b0);
          check_eq("bin_mode1", d1_bin, b1);
          check_eq("bin_mode2", d2_bin, b2);
          check_eq("zero_o", zero_o, z);
          check_eq("multi_o", multi_o, m);
          if (last_low < e.acc) check_eq("latency", cyc - e.acc, 2);
          hs_err = z || m;
        end
      end
`ifdef GNRC_ONEHOT2BIN_ERRCNT_EN
      check_eq("err_cnt", err_cnt_o, err_m);
      if (err_clr_i) err_m = 0;
      else if (hs_err && err_m < 3) err_m++;
`endif
      if (!ready_i) last_low = cyc;
      if (valid_i && ready_o) sbq.push_back('{oh: onehot_i, acc: cyc});
      held       = valid_o && !ready_i;
      held_bin   = bin_o;
      held_zero  = zero_o;
      held_multi = multi_o;
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] x);
    int w;
    w = 0;
    valid_i  = 1'b1;
    onehot_i = x;
    @(negedge clk_i);
    while (!ready_o && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    if (!ready_o) check_eq("send_accept", ready_o, 1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    logic [7:0] beats [6];
    int idx;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; onehot_i = '0; err_clr_i = 1'b0;
    c_valid_i = 1'b0; c_ready_i = 1'b0; c_onehot = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("ready_after_rst", ready_o, 1);
    check_eq("valid_after_rst", valid_o, 0);
    @(posedge clk_i); #1;

    // Back-to-back one-hot beats with the output always ready.
    send(8'h01); send(8'h02); send(8'h80);
    // Multi-hot and all-zero beats.
    send(8'h12); send(8'h00);
    idle(4);

    // Six back-to-back beats with the output stalled for cycles 3..7.
    beats = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h22, 8'h08};
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      ready_i  = !(c >= 3 && c <= 7);
      valid_i  = (idx < 6);
      onehot_i = (idx < 6) ? beats[idx] : 8'h00;
      @(negedge clk_i);
      if (c == 5) check_eq("stall_ready_o", ready_o, 0);
      if (valid_i && ready_o) idx++;
      @(posedge clk_i); #1;
    end
    check_eq("stall_all_sent", idx, 6);
    check_eq("stall_drained", sbq.size(), 0);

    // Reset with two beats in flight.
    ready_i = 1'b1;
    send(8'h04); send(8'h08);
    rst_i = 1'b1;
    #1 check_eq("rst_async_valid_o", valid_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("ready_after_midrst", ready_o, 1);
    check_eq("valid_after_midrst", valid_o, 0);
    @(posedge clk_i); #1;
    idle(5);

    // Randomized traffic with random backpressure and counter clears.
    for (int c = 0; c < 400; c++) begin
      valid_i   = ($urandom_range(0, 3) != 0);
      ready_i   = ($urandom_range(0, 3) != 0);
      onehot_i  = 8'(rand_vec(8));
      err_clr_i = ($urandom_range(0, 15) == 0);
      @(posedge clk_i); #1;
    end
    err_clr_i = 1'b0;
    ready_i   = 1'b1;
    idle(10);
    check_eq("final_drained", sbq.size(), 0);

    // Combinational N=13 MODE2 instance.
    for (int c = 0; c < 30; c++) begin
      int b;
      bit z, m;
      c_valid_i = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      c_ready_i = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      c_onehot  = (c == 0) ? 13'h1000 : 13'(rand_vec(13));
      @(negedge clk_i);
      ref_encode(32'(c_onehot), 13, 2, b, z, m);
      check_eq("comb_bin", c_bin, b);
      check_eq("comb_zero", c_zero, z);
      check_eq("comb_multi", c_multi, m);
      check_eq("comb_valid", c_valid_o, c_valid_i);
      check_eq("comb_ready", c_ready_o, c_ready_i);
      @(posedge clk_i); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
